// File: rtl/ext_mem_mp_if.sv
// Flat Koika-style bus for ext_mem_mp: per-channel {get_enable, put_enable, put_request} in arg,
// {get_ready, put_ready, get_response} in out.
interface ext_mem_mp_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int SLICE_W = DATA_WIDTH / 8 + 32 + DATA_WIDTH + 2;

  logic [NUM_PORTS*SLICE_W-1:0] arg;
  logic [NUM_PORTS*SLICE_W-1:0] out;

  modport master (output arg, input out);
  modport slave  (input arg, output out);
endinterface

// File: rtl/ext_mem_mp.sv
// Multi-port word memory: one request slot + response FIFO per channel, round-robin access; put->get_ready 2 cycles uncontended.
// Slot refuses puts while occupied and ungranted; no grant while the response FIFO is full. Option: EXT_MEM_MP_BOUNDS_CHECK_EN.
module ext_mem_mp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
endmodule

module ext_mem_mp #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int RESP_DEPTH    = 2
) (
  input logic       CLK,
  input logic       RST_N,
  ext_mem_mp_if.slave bus
);
  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int REQ_W   = BE_W + 32 + DATA_WIDTH;
  localparam int SLICE_W = REQ_W + 2;
  localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef struct packed {
    logic [BE_W-1:0]       byte_en;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                 put_req   [NUM_PORTS];
  req_t                 slot_req  [NUM_PORTS];
  req_t                 fifo_head [NUM_PORTS];
  logic [NUM_PORTS-1:0] put_en, get_en, put_rdy, get_rdy, slot_vld, fifo_full, gnt;

  logic                  gnt_any;
  logic [PTR_W-1:0]      gnt_idx, rr_ptr;
  req_t                  gnt_req, resp;
  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
  logic [ADDRESS_WIDTH-1:0] widx;
  logic [DATA_WIDTH-1:0] old_word;
  logic                  oob;

  // Grant uses only registered state, so put_ready never depends on get_enable.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_req = '0;
    gnt     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!gnt_any && slot_vld[idx] && !fifo_full[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_req  = slot_req[idx];
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign widx     = gnt_req.addr[ADDRESS_WIDTH+1:2];
  assign old_word = mem[widx];

`ifdef EXT_MEM_MP_BOUNDS_CHECK_EN
  assign oob = (|gnt_req.addr[31:ADDRESS_WIDTH+2]) || (|gnt_req.addr[1:0]);
`else
  // Upper and sub-word address bits are deliberately ignored: addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, gnt_req.addr[31:ADDRESS_WIDTH+2], gnt_req.addr[1:0]};
  assign oob = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (gnt_any && !oob) begin
      for (int b = 0; b < BE_W; b++) begin
        if (gnt_req.byte_en[b]) mem[widx][b*8 +: 8] <= gnt_req.data[b*8 +: 8];
      end
    end
  end

  // Response always carries the pre-write word, for reads and writes alike.
  always_comb begin
    resp         = gnt_req;
    resp.data    = oob ? '1 : old_word;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ch
    logic vld;
    req_t req;

    assign put_req[p] = bus.arg[p*SLICE_W +: REQ_W];
    assign put_en[p]  = bus.arg[p*SLICE_W + REQ_W];
    assign get_en[p]  = bus.arg[p*SLICE_W + REQ_W + 1];
    assign put_rdy[p] = !vld || gnt[p];
    assign slot_vld[p] = vld;
    assign slot_req[p] = req;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        vld <= 1'b0;
        req <= '0;
      end else if (put_en[p] && put_rdy[p]) begin
        vld <= 1'b1;
        req <= put_req[p];
      end else if (gnt[p]) begin
        vld <= 1'b0;
      end
    end

    logic fifo_empty;
    ext_mem_mp_fifo #(.WIDTH(REQ_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (gnt[p]),
      .push_dat (resp),
      .pop      (get_en[p] && !fifo_empty),
      .pop_dat  (fifo_head[p]),
      .empty    (fifo_empty),
      .full     (fifo_full[p])
    );
    assign get_rdy[p] = !fifo_empty;

    assign bus.out[p*SLICE_W +: SLICE_W] = {get_rdy[p], put_rdy[p], fifo_head[p]};
  end
endmodule

// File: tb/tb_ext_mem_mp.sv
// Directed bench for ext_mem_mp: expectations queued per channel at issue, compared by a monitor on every pop.
module tb_ext_mem_mp;
  localparam int NP = 2, AW = 14, DW = 32, RD = 2;
  localparam int REQ_W = DW / 8 + 32 + DW;
  localparam int SW = REQ_W + 2;
`ifdef EXT_MEM_MP_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  ext_mem_mp_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();
  ext_mem_mp #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(RD)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  logic [NP-1:0]    get_en, put_en, gr, pr;
  logic [REQ_W-1:0] put_req [NP];
  logic [REQ_W-1:0] resp    [NP];

  for (genvar p = 0; p < NP; p++) begin : g_io
    assign bus.arg[p*SW +: SW] = {get_en[p], put_en[p], put_req[p]};
    assign gr[p]   = bus.out[p*SW + REQ_W + 1];
    assign pr[p]   = bus.out[p*SW + REQ_W];
    assign resp[p] = bus.out[p*SW +: REQ_W];
  end

  typedef struct {
    logic [REQ_W-1:0] r;
    bit               full;
  } exp_t;

  exp_t exp_q [NP][$];
  int checks, passes;

  task automatic chk(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic chk_b(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // full=0 leaves the data field unchecked (old contents not yet known).
  task automatic drive(input int ch, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_d, input bit full, input bit acc, input bit keep);
    exp_t e;
    chk_b($sformatf("put_ready_ch%0d_addr_%h", ch, addr), 4'(pr[ch]), 4'(acc));
    put_en[ch]  = 1'b1;
    put_req[ch] = {be, addr, data};
    e.r    = {be, addr, exp_d};
    e.full = full;
    if (acc && keep) exp_q[ch].push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    put_en = '0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      for (int c = 0; c < NP; c++) begin
        if (RST_N && gr[c] && get_en[c]) begin
          if (exp_q[c].size() == 0) begin
            checks++;
            $display("FAIL unexpected_resp_ch%0d: got %h, expected no response", c, resp[c]);
          end else begin
            e = exp_q[c].pop_front();
            if (e.full) chk($sformatf("resp_ch%0d", c), resp[c], e.r);
            else chk($sformatf("resp_hdr_ch%0d", c), {resp[c][REQ_W-1:DW], {DW{1'b0}}}, {e.r[REQ_W-1:DW], {DW{1'b0}}});
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 50) begin
      @(posedge CLK);
      n++;
    end
    #1;
    checks++;
    if ((exp_q[0].size() + exp_q[1].size()) == 0) passes++;
    else $display("FAIL drain_%s: %0d responses outstanding, expected 0", name, exp_q[0].size() + exp_q[1].size());
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    checks = 0;
    passes = 0;
    RST_N  = 1'b0;
    get_en = '0;
    put_en = '0;
    put_req[0] = '0;
    put_req[1] = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge CLK);
    #1;
    chk_b("reset_get_ready", 4'(gr), 4'b0000);
    chk_b("reset_put_ready", 4'(pr), 4'b0011);
    RST_N  = 1'b1;
    get_en = 2'b11;
    @(posedge CLK);
    #1;

    // Single write then read, with latency check
    drive(0, 4'hF, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    chk_b("latency_t1_get_ready", 4'(gr[0]), 4'd0);
    drive(0, 4'h0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
    step();
    chk_b("latency_t2_get_ready", 4'(gr[0]), 4'd1);
    drain("single");

    // Byte-masked write
    drive(0, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    drive(0, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h11223344, 1'b1, 1'b1, 1'b1);
    step();
    drive(0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b1, 1'b1, 1'b1);
    step();
    drain("bytemask");

    // Preload, then reset so the arbiter pointer is 0 for the contention case
    drive(1, 4'hF, 32'h30, 32'h30303030, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(0, 4'hF, 32'h40, 32'h40404040, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    drain("preload");
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    drive(0, 4'h0, 32'h30, 32'h0, 32'h30303030, 1'b1, 1'b1, 1'b1);
    drive(1, 4'h0, 32'h40, 32'h0, 32'h40404040, 1'b1, 1'b1, 1'b1);
    step();
    chk_b("contend_t1_get_ready", 4'(gr), 4'b0000);
    drive(0, 4'h0, 32'h40, 32'h0, 32'h40404040, 1'b1, 1'b1, 1'b1);
    drive(1, 4'h0, 32'h30, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    chk_b("contend_t2_get_ready", 4'(gr), 4'b0001);
    step();
    chk_b("contend_t3_get_ready", 4'(gr), 4'b0010);
    step();
    chk_b("contend_t4_ch0_second", 4'(gr[0]), 4'd1);
    drain("contend");

    // Backpressure: no gets on ch0, four back-to-back reads
    get_en[0] = 1'b0;
    drive(0, 4'h0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
    step();
    drive(0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b1, 1'b1, 1'b1);
    step();
    drive(0, 4'h0, 32'h30, 32'h0, 32'h30303030, 1'b1, 1'b1, 1'b1);
    step();
    drive(0, 4'h0, 32'h40, 32'h0, 32'h40404040, 1'b1, 1'b0, 1'b1);
    step();
    chk_b("bp_put_ready", 4'(pr[0]), 4'd0);
    chk_b("bp_get_ready", 4'(gr[0]), 4'd1);
    get_en[0] = 1'b1;
    drain("backpressure");

    // Reset with two responses queued
    get_en[0] = 1'b0;
    drive(0, 4'h0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 4'h0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk_b("pre_reset_get_ready", 4'(gr[0]), 4'd1);
    RST_N = 1'b0;
    #1;
    chk_b("async_reset_get_ready", 4'(gr), 4'b0000);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    chk_b("post_reset_put_ready", 4'(pr), 4'b0011);
    chk_b("post_reset_get_ready", 4'(gr), 4'b0000);
    get_en[0] = 1'b1;
    @(posedge CLK);
    #1;
    drive(0, 4'h0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
    step();
    drain("after_reset");

    // Out-of-range / unaligned addresses on ch1
    drive(1, 4'hF, 32'h0, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    drive(1, 4'hF, 32'h0001_0000, 32'h12345678, BOUNDS ? 32'hFFFFFFFF : 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1);
    step();
    drive(1, 4'h0, 32'h0, 32'h0, BOUNDS ? 32'h5A5A5A5A : 32'h12345678, 1'b1, 1'b1, 1'b1);
    step();
    drive(1, 4'h0, 32'h13, 32'h0, BOUNDS ? 32'hFFFFFFFF : 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
    step();
    drain("address");

    // Same word from two channels in one cycle: write granted first, read sees it
    drive(0, 4'hF, 32'h50, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(1, 4'h0, 32'h50, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
    step();
    drain("same_word");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
